// File: rtl/spi_xip_apb_bridge.sv
// APB front end for the wishbone SPI master: turns XIP-window reads into a fixed
// SPI programming sequence on the core and passes register-window accesses straight through.
module spi_xip_apb_bridge #(
    parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
    parameter logic [31:0] FLASH_END  = 32'h3fff_ffff,
    parameter logic [31:0] REG_BASE   = 32'h1000_1000,
    parameter logic [31:0] REG_END    = 32'h1000_1fff,
    parameter logic [7:0]  READ_CMD   = 8'h03,
    parameter logic [15:0] DIVIDER    = 16'h0001,
    parameter int          SS_IDX     = 0,
    parameter bit          BSWAP      = 1'b1,
    parameter bit          BUF_EN     = 1'b1,
    parameter int          MAX_POLL   = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic [2:0]  in_pprot,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr,
    output logic [4:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam int          CW        = $clog2(MAX_POLL + 1);
    localparam logic [CW-1:0] POLL_MAX = CW'(MAX_POLL);
    localparam logic [31:0] SS_MASK   = 32'h1 << SS_IDX;
    localparam logic [31:0] CTRL_GO   = 32'h0000_0140;

    typedef enum logic [3:0] {
        S_IDLE, S_REG, S_TX1, S_DIV, S_SS, S_GO, S_POLL, S_CLR, S_RD, S_RESP, S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [21:0]   addr_q, addr_d;
    logic          init_done_q, init_done_d;
    logic          buf_valid_q, buf_valid_d;
    logic [21:0]   buf_addr_q, buf_addr_d;
    logic [31:0]   buf_data_q, buf_data_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [CW-1:0] poll_cnt_q, poll_cnt_d;
    logic [4:0]    wb_adr_q, wb_adr_d;
    logic [31:0]   wb_dat_q, wb_dat_d;
    logic [3:0]    wb_sel_q, wb_sel_d;
    logic          wb_we_q, wb_we_d;
    logic          wb_stb_q, wb_stb_d;
    logic          pready_q, pready_d;
    logic [31:0]   prdata_q, prdata_d;
    logic          pslverr_q, pslverr_d;

    logic          is_flash, is_reg, buf_hit;
    logic [4:0]    op_adr;
    logic [31:0]   op_dat;
    logic [3:0]    op_sel;
    logic          op_we;
    logic [31:0]   rx_word;
    logic [CW-1:0] poll_next;
    logic          unused_pprot;

    assign unused_pprot = ^in_pprot;

    assign is_flash  = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_END);
    assign is_reg    = (in_paddr >= REG_BASE) && (in_paddr <= REG_END);
    assign buf_hit   = BUF_EN && buf_valid_q && (buf_addr_q == in_paddr[23:2]);
    assign rx_word   = BSWAP ? {wb_dat_i[7:0], wb_dat_i[15:8], wb_dat_i[23:16], wb_dat_i[31:24]}
                             : wb_dat_i;
    assign poll_next = poll_cnt_q + CW'(1);

    // Wishbone operation issued by each step of the flash read sequence.
    always_comb begin
        op_adr = 5'h00;
        op_dat = 32'h0;
        op_sel = 4'hf;
        op_we  = 1'b1;
        case (state_q)
            S_TX1:        begin op_adr = 5'h04; op_dat = {READ_CMD, addr_q, 2'b00}; end
            S_DIV:        begin op_adr = 5'h14; op_dat = {16'h0, DIVIDER}; end
            S_SS:         begin op_adr = 5'h18; op_dat = SS_MASK; end
            S_GO:         begin op_adr = 5'h10; op_dat = CTRL_GO; end
            S_POLL:       begin op_adr = 5'h10; op_sel = 4'h0; op_we = 1'b0; end
            S_CLR, S_ERR: begin op_adr = 5'h18; end
            S_RD:         begin op_adr = 5'h00; op_we = 1'b0; end
            default:      begin op_sel = 4'h0; op_we = 1'b0; end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        init_done_d = init_done_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        rdata_d     = rdata_q;
        poll_cnt_d  = poll_cnt_q;
        wb_adr_d    = wb_adr_q;
        wb_dat_d    = wb_dat_q;
        wb_sel_d    = wb_sel_q;
        wb_we_d     = wb_we_q;
        wb_stb_d    = wb_stb_q;
        pready_d    = 1'b0;
        prdata_d    = 32'h0;
        pslverr_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // pready_q high means the previous access is still being acknowledged.
                if (in_psel && in_penable && !pready_q) begin
                    if (is_reg) begin
                        wb_adr_d = in_paddr[4:0];
                        wb_dat_d = in_pwdata;
                        wb_sel_d = in_pstrb;
                        wb_we_d  = in_pwrite;
                        wb_stb_d = 1'b1;
                        state_d  = S_REG;
                        if (in_pwrite) buf_valid_d = 1'b0;
                    end else if (is_flash && !in_pwrite) begin
                        if (buf_hit) begin
                            pready_d = 1'b1;
                            prdata_d = buf_data_q;
                        end else begin
                            addr_d     = in_paddr[23:2];
                            poll_cnt_d = '0;
                            state_d    = S_TX1;
                        end
                    end else begin
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end
                end
            end
            S_REG: begin
                if (wb_ack_i || wb_err_i) begin
                    wb_stb_d  = 1'b0;
                    pready_d  = 1'b1;
                    prdata_d  = wb_dat_i;
                    pslverr_d = wb_err_i;
                    state_d   = S_IDLE;
                end
            end
            S_RESP: begin
                pready_d = 1'b1;
                prdata_d = rdata_q;
                if (BUF_EN) begin
                    buf_valid_d = 1'b1;
                    buf_addr_d  = addr_q;
                    buf_data_d  = rdata_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                // Strobe low on entry gives the one idle cycle between sequence writes.
                if (!wb_stb_q) begin
                    wb_adr_d = op_adr;
                    wb_dat_d = op_dat;
                    wb_sel_d = op_sel;
                    wb_we_d  = op_we;
                    wb_stb_d = 1'b1;
                end else if (wb_err_i && state_q != S_ERR) begin
                    wb_stb_d = 1'b0;
                    state_d  = S_ERR;
                end else if (wb_ack_i || wb_err_i) begin
                    wb_stb_d = 1'b0;
                    case (state_q)
                        S_TX1: state_d = init_done_q ? S_SS : S_DIV;
                        S_DIV: begin init_done_d = 1'b1; state_d = S_SS; end
                        S_SS:  state_d = S_GO;
                        S_GO:  state_d = S_POLL;
                        S_POLL: begin
                            if (!wb_dat_i[8]) begin
                                state_d = S_CLR;
                            end else begin
                                poll_cnt_d = poll_next;
                                if (poll_next == POLL_MAX) state_d = S_ERR;
                            end
                        end
                        S_CLR: state_d = S_RD;
                        S_RD: begin
                            rdata_d = rx_word;
                            state_d = S_RESP;
                        end
                        S_ERR: begin
                            pready_d  = 1'b1;
                            pslverr_d = 1'b1;
                            state_d   = S_IDLE;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            init_done_q <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            rdata_q     <= '0;
            poll_cnt_q  <= '0;
            wb_adr_q    <= '0;
            wb_dat_q    <= '0;
            wb_sel_q    <= '0;
            wb_we_q     <= 1'b0;
            wb_stb_q    <= 1'b0;
            pready_q    <= 1'b0;
            prdata_q    <= '0;
            pslverr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            init_done_q <= init_done_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            rdata_q     <= rdata_d;
            poll_cnt_q  <= poll_cnt_d;
            wb_adr_q    <= wb_adr_d;
            wb_dat_q    <= wb_dat_d;
            wb_sel_q    <= wb_sel_d;
            wb_we_q     <= wb_we_d;
            wb_stb_q    <= wb_stb_d;
            pready_q    <= pready_d;
            prdata_q    <= prdata_d;
            pslverr_q   <= pslverr_d;
        end
    end

    assign wb_adr_o   = wb_adr_q;
    assign wb_dat_o   = wb_dat_q;
    assign wb_sel_o   = wb_sel_q;
    assign wb_we_o    = wb_we_q;
    assign wb_stb_o   = wb_stb_q;
    assign wb_cyc_o   = wb_stb_q;
    assign in_pready  = pready_q;
    assign in_prdata  = prdata_q;
    assign in_pslverr = pslverr_q;

endmodule

// File: tb/tb_spi_xip_apb_bridge.sv
// Bench for spi_xip_apb_bridge: wishbone SPI-core model backed by a flash byte array,
// APB master tasks, and a word-level scoreboard for XIP reads and the read buffer.
module tb_spi_xip_apb_bridge;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_paddr = '0;
    logic        in_psel = 1'b0, in_penable = 1'b0, in_pwrite = 1'b0;
    logic [2:0]  in_pprot = '0;
    logic [31:0] in_pwdata = '0;
    logic [3:0]  in_pstrb = '0;
    logic        in_pready, in_pslverr;
    logic [31:0] in_prdata;
    logic [4:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_stb_o, wb_cyc_o;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;

    spi_xip_apb_bridge #(.MAX_POLL(4)) dut (
        .clock(clock), .reset(reset),
        .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable), .in_pprot(in_pprot),
        .in_pwrite(in_pwrite), .in_pwdata(in_pwdata), .in_pstrb(in_pstrb),
        .in_pready(in_pready), .in_prdata(in_prdata), .in_pslverr(in_pslverr),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clock = ~clock;

    // SPI core model: register file, flash byte stream behind RX0, busy countdown after GO.
    logic [7:0]  mem [0:1023];
    logic [31:0] regs [0:31] = '{default: 32'h0};
    logic [31:0] shadow [0:31] = '{default: 32'h0};
    logic [31:0] last_tx1 = '0, last_ctrl = '0, last_ss = '0, last_div = '0;
    int          n_acks = 0, n_div = 0, n_poll = 0, n_ssw = 0, busy_left = 0;
    logic        hold_busy = 1'b0;

    function automatic logic [31:0] be_word(input logic [31:0] a);
        int w;
        w = int'(a[9:0]) & ~3;
        return {mem[w], mem[w+1], mem[w+2], mem[w+3]};
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            wb_ack_i <= 1'b0;
        end else if (wb_ack_i) begin
            wb_ack_i <= 1'b0;
        end else if (wb_stb_o && wb_cyc_o && $urandom_range(0, 2) != 0) begin
            wb_ack_i <= 1'b1;
            n_acks   <= n_acks + 1;
            if (wb_we_o) begin
                logic [31:0] m;
                m = {{8{wb_sel_o[3]}}, {8{wb_sel_o[2]}}, {8{wb_sel_o[1]}}, {8{wb_sel_o[0]}}};
                regs[wb_adr_o] <= (regs[wb_adr_o] & ~m) | (wb_dat_o & m);
                case (wb_adr_o)
                    5'h04: last_tx1 <= wb_dat_o;
                    5'h10: begin last_ctrl <= wb_dat_o; busy_left <= int'($urandom_range(0, 2)); end
                    5'h14: begin n_div <= n_div + 1; last_div <= wb_dat_o; end
                    5'h18: begin last_ss <= wb_dat_o; n_ssw <= n_ssw + 1; end
                    default: ;
                endcase
            end else begin
                case (wb_adr_o)
                    5'h00: wb_dat_i <= be_word(last_tx1);
                    5'h10: begin
                        n_poll <= n_poll + 1;
                        wb_dat_i <= {23'h0, (hold_busy || busy_left > 0), 8'h0};
                        if (busy_left > 0) busy_left <= busy_left - 1;
                    end
                    default: wb_dat_i <= regs[wb_adr_o];
                endcase
            end
        end
    end

    int n_cmp = 0, n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apb(input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd, output logic err,
                       output int cyc);
        in_paddr = a; in_pwrite = w; in_pwdata = wd; in_pstrb = st;
        in_psel = 1'b1; in_penable = 1'b0;
        @(posedge clock); #1 in_penable = 1'b1;
        cyc = 0;
        do begin @(posedge clock); #1; cyc++; end while (!in_pready && cyc < 2000);
        chk("pready_seen", {31'h0, in_pready}, 32'h1);
        rd = in_prdata; err = in_pslverr;
        in_psel = 1'b0; in_penable = 1'b0;
    endtask

    // Little-endian word assembled from the flash byte stream at the word address.
    function automatic logic [31:0] exp_word(input logic [31:0] a);
        int w;
        w = int'(a[9:0]) & ~3;
        return {mem[w+3], mem[w+2], mem[w+1], mem[w]};
    endfunction

    logic [31:0] rd;
    logic        err;
    int          cyc, a0, d0, p0, s0;
    logic        buf_ok = 1'b0;
    logic [21:0] buf_w = '0;

    task automatic flash_rd(input string tag, input logic [31:0] a);
        logic hit;
        hit = buf_ok && (buf_w == a[23:2]);
        a0 = n_acks;
        apb(a, 1'b0, 32'h0, 4'h0, rd, err, cyc);
        chk({tag, "_data"}, rd, exp_word(a));
        chk({tag, "_err"}, {31'h0, err}, 32'h0);
        if (hit) begin
            chk({tag, "_hit_wb"}, 32'(n_acks - a0), 32'h0);
            chk({tag, "_hit_lat"}, 32'(cyc), 32'h1);
        end else begin
            chk({tag, "_tx1"}, last_tx1, {8'h03, a[23:2], 2'b00});
            chk({tag, "_ss_clr"}, last_ss, 32'h0);
        end
        buf_ok = 1'b1; buf_w = a[23:2];
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[16] = 8'hAA; mem[17] = 8'hBB; mem[18] = 8'hCC; mem[19] = 8'hDD;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_pready", {31'h0, in_pready}, 32'h0);
        chk("rst_stb", {30'h0, wb_stb_o, wb_cyc_o}, 32'h0);
        chk("rst_prdata", in_prdata, 32'h0);

        flash_rd("first", 32'h3000_0010);
        chk("first_literal", rd, 32'hDDCC_BBAA);
        chk("first_div_cnt", 32'(n_div), 32'h1);
        chk("first_div_val", last_div, 32'h1);
        chk("first_ctrl", last_ctrl, 32'h140);
        @(posedge clock); #1;
        chk("pulse_pready", {31'h0, in_pready}, 32'h0);
        chk("pulse_prdata", in_prdata, 32'h0);

        flash_rd("hit", 32'h3000_0010);
        flash_rd("next", 32'h3000_0016);
        chk("next_div_skip", 32'(n_div), 32'h1);

        apb(32'h1000_1018, 1'b1, 32'h1, 4'hf, rd, err, cyc);
        chk("regw_err", {31'h0, err}, 32'h0);
        chk("regw_ss", last_ss, 32'h1);
        shadow[5'h18] = 32'h1;
        buf_ok = 1'b0;
        apb(32'h1000_1018, 1'b0, 32'h0, 4'hf, rd, err, cyc);
        chk("regr_data", rd, 32'h1);
        a0 = n_acks;
        flash_rd("after_regw", 32'h3000_0010);
        chk("after_regw_traffic", 32'(n_acks > a0), 32'h1);

        a0 = n_acks;
        apb(32'h3000_0000, 1'b1, 32'hdead_beef, 4'hf, rd, err, cyc);
        chk("fwr_err", {31'h0, err}, 32'h1);
        chk("fwr_lat", 32'(cyc), 32'h1);
        apb(32'h2000_0000, 1'b0, 32'h0, 4'hf, rd, err, cyc);
        chk("hole_err", {31'h0, err}, 32'h1);
        chk("hole_data", rd, 32'h0);
        chk("err_no_wb", 32'(n_acks - a0), 32'h0);

        for (int it = 0; it < 24; it++) begin
            int op;
            logic [4:0] ra;
            logic [31:0] wd, m;
            logic [3:0] st;
            op = int'($urandom_range(0, 8));
            case ($urandom_range(0, 2))
                0: ra = 5'h08;
                1: ra = 5'h0c;
                default: ra = 5'h1c;
            endcase
            if (op <= 5) begin
                flash_rd("rnd_flash", 32'h3000_0000 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3)));
            end else if (op <= 7) begin
                wd = $urandom; st = 4'($urandom);
                apb(32'h1000_1000 | 32'(ra), 1'b1, wd, st, rd, err, cyc);
                m = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
                shadow[ra] = (shadow[ra] & ~m) | (wd & m);
                buf_ok = 1'b0;
                chk("rnd_regw_err", {31'h0, err}, 32'h0);
            end else begin
                apb(32'h1000_1000 | 32'(ra), 1'b0, 32'h0, 4'hf, rd, err, cyc);
                chk("rnd_regr", rd, shadow[ra]);
            end
        end

        flash_rd("pre_tmo", 32'h3000_0040);
        hold_busy = 1'b1;
        p0 = n_poll; s0 = n_ssw;
        apb(32'h3000_0100, 1'b0, 32'h0, 4'h0, rd, err, cyc);
        chk("tmo_err", {31'h0, err}, 32'h1);
        chk("tmo_data", rd, 32'h0);
        chk("tmo_polls", 32'(n_poll - p0), 32'h4);
        chk("tmo_ss_clr", last_ss, 32'h0);
        chk("tmo_ss_writes", 32'(n_ssw - s0), 32'h2);
        hold_busy = 1'b0;
        flash_rd("post_tmo_hit", 32'h3000_0040);

        hold_busy = 1'b1;
        p0 = n_poll;
        in_paddr = 32'h3000_0200; in_pwrite = 1'b0; in_psel = 1'b1; in_penable = 1'b0;
        @(posedge clock); #1 in_penable = 1'b1;
        for (int i = 0; i < 200 && n_poll == p0; i++) @(posedge clock);
        chk("rst_poll_seen", 32'(n_poll > p0), 32'h1);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        chk("midrst_stb", {30'h0, wb_stb_o, wb_cyc_o}, 32'h0);
        chk("midrst_pready", {31'h0, in_pready}, 32'h0);
        in_psel = 1'b0; in_penable = 1'b0; hold_busy = 1'b0;
        @(posedge clock); #1 reset = 1'b0;
        buf_ok = 1'b0;
        repeat (3) @(posedge clock);
        #1 chk("postrst_pready", {31'h0, in_pready}, 32'h0);
        d0 = n_div;
        flash_rd("postrst", 32'h3000_0200);
        chk("postrst_div", 32'(n_div - d0), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
